// File: rtl/forward_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forward_control_pkg
// Description : Opcodes, result classes and forward-select codes shared by the
//               hazard/forwarding controller, write controller and ALU mux.
// Revision    : 1.0 - initial release
// ============================================================================
package forward_control_pkg;

    localparam logic [4:0] c_op_bne   = 5'h10;
    localparam logic [4:0] c_op_be    = 5'h11;
    localparam logic [4:0] c_op_j     = 5'h12;
    localparam logic [4:0] c_op_bner  = 5'h13;
    localparam logic [4:0] c_op_ber   = 5'h14;
    localparam logic [4:0] c_op_jr    = 5'h15;
    localparam logic [4:0] c_op_load  = 5'h16;
    localparam logic [4:0] c_op_li    = 5'h17;
    localparam logic [4:0] c_op_store = 5'h18;
    localparam logic [4:0] c_op_nop   = 5'h1F;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_LOAD = 2'b10,
        CLS_LI   = 2'b11
    } fwd_class_e;

    localparam logic [2:0] c_fwd_rf       = 3'b000;
    localparam logic [2:0] c_fwd_ex_alu   = 3'b001;
    localparam logic [2:0] c_fwd_ex_load  = 3'b010;
    localparam logic [2:0] c_fwd_ex_li    = 3'b011;
    localparam logic [2:0] c_fwd_mem_alu  = 3'b101;
    localparam logic [2:0] c_fwd_mem_load = 3'b110;
    localparam logic [2:0] c_fwd_mem_li   = 3'b111;

    // CLS_NONE marks a non-writer; everything not listed is an ALU writer.
    function automatic fwd_class_e op_class(input logic [4:0] op);
        case (op)
            c_op_load:  op_class = CLS_LOAD;
            c_op_li:    op_class = CLS_LI;
            c_op_bne, c_op_be, c_op_j, c_op_bner, c_op_ber,
            c_op_jr, c_op_store, c_op_nop:
                        op_class = CLS_NONE;
            default:    op_class = CLS_ALU;
        endcase
    endfunction

    function automatic logic reads_r1(input logic [4:0] op);
        reads_r1 = (op_class(op) == CLS_ALU) || (op == c_op_bner) ||
                   (op == c_op_ber) || (op == c_op_jr);
    endfunction

    function automatic logic reads_r2(input logic [4:0] op);
        reads_r2 = (op_class(op) == CLS_ALU) || (op == c_op_bner) ||
                   (op == c_op_ber);
    endfunction

    function automatic logic reads_rd(input logic [4:0] op);
        reads_rd = (op == c_op_store);
    endfunction

    function automatic logic [2:0] fwd_code(input logic [1:0] cls, input logic from_memwb);
        case (cls)
            CLS_ALU:  fwd_code = from_memwb ? c_fwd_mem_alu  : c_fwd_ex_alu;
            CLS_LOAD: fwd_code = from_memwb ? c_fwd_mem_load : c_fwd_ex_load;
            CLS_LI:   fwd_code = from_memwb ? c_fwd_mem_li   : c_fwd_ex_li;
            default:  fwd_code = c_fwd_rf;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_control_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_match
// Description : Resolves one source register against the IDEX and EXMEM slots
//               into a forward code and a stall request. FWD_MEMWB_EN selects
//               whether EXMEM producers are forwarded or stalled on.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
    import forward_control_pkg::*;
(
    input  logic       i_en,
    input  logic       i_load_stalls,
    input  logic [2:0] i_addr,
    input  logic       i_idex_valid,
    input  logic [2:0] i_idex_rd,
    input  logic [1:0] i_idex_cls,
    input  logic       i_exmem_valid,
    input  logic [2:0] i_exmem_rd,
    input  logic [1:0] i_exmem_cls,
    output logic [2:0] o_code,
    output logic       o_stall
);

    logic w_young_hit;
    logic w_old_hit;
    logic w_load_hit;
    logic w_old_stall;

    // The IDEX producer is younger, so it shadows any EXMEM producer.
    assign w_young_hit = i_en && i_idex_valid && (i_idex_rd == i_addr);
    assign w_old_hit   = i_en && i_exmem_valid && (i_exmem_rd == i_addr) && !w_young_hit;
    assign w_load_hit  = w_young_hit && (i_idex_cls == CLS_LOAD);

`ifdef FWD_MEMWB_EN
    assign w_old_stall = 1'b0;
`else
    assign w_old_stall = w_old_hit;
`endif

    assign o_stall = (i_load_stalls && w_load_hit) || w_old_stall;

    // Without MEMWB forwarding an old hit always stalls, so its 1xx code is
    // replaced by the bubble's 000 before it can reach the outputs.
    always_comb begin
        o_code = c_fwd_rf;
        if (w_young_hit) begin
            o_code = fwd_code(i_idex_cls, 1'b0);
        end else if (w_old_hit) begin
            o_code = fwd_code(i_exmem_cls, 1'b1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/forward_control.sv
`default_nettype none
// ============================================================================
// Module      : forward_control
// Description : Hazard and forwarding controller for the 5-stage 8-bit
//               pipeline. Build option FWD_MEMWB_EN enables MEMWB forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_control
    import forward_control_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] IFID_OPCODE,
    input  logic [2:0] IFID_RD_ADDR,
    input  logic [3:0] IFID_R1_ADDR,
    input  logic [3:0] IFID_R2_ADDR,
    input  logic       FLUSH,
    output logic       STALL,
    output logic [2:0] RAM_FORWARD,
    output logic [2:0] ALU_FWD_A,
    output logic [2:0] ALU_FWD_B
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e     r_state;
    logic       r_idex_valid;
    logic [2:0] r_idex_rd;
    logic [1:0] r_idex_cls;
    logic       r_exmem_valid;
    logic [2:0] r_exmem_rd;
    logic [1:0] r_exmem_cls;

    logic [1:0] w_cls;
    logic [2:0] w_code_a;
    logic [2:0] w_code_b;
    logic [2:0] w_code_s;
    logic       w_stall_a;
    logic       w_stall_b;
    logic       w_stall_s;
    logic       w_stall;
    logic       w_bubble;
    logic       w_unused_src_msb;

    assign w_cls            = op_class(IFID_OPCODE);
    assign w_unused_src_msb = IFID_R1_ADDR[3] ^ IFID_R2_ADDR[3];

    fwd_match u_match_a (
        .i_en          (reads_r1(IFID_OPCODE)),
        .i_load_stalls (1'b1),
        .i_addr        (IFID_R1_ADDR[2:0]),
        .i_idex_valid  (r_idex_valid),
        .i_idex_rd     (r_idex_rd),
        .i_idex_cls    (r_idex_cls),
        .i_exmem_valid (r_exmem_valid),
        .i_exmem_rd    (r_exmem_rd),
        .i_exmem_cls   (r_exmem_cls),
        .o_code        (w_code_a),
        .o_stall       (w_stall_a)
    );

    fwd_match u_match_b (
        .i_en          (reads_r2(IFID_OPCODE)),
        .i_load_stalls (1'b1),
        .i_addr        (IFID_R2_ADDR[2:0]),
        .i_idex_valid  (r_idex_valid),
        .i_idex_rd     (r_idex_rd),
        .i_idex_cls    (r_idex_cls),
        .i_exmem_valid (r_exmem_valid),
        .i_exmem_rd    (r_exmem_rd),
        .i_exmem_cls   (r_exmem_cls),
        .o_code        (w_code_b),
        .o_stall       (w_stall_b)
    );

    // Store data is consumed a stage later, so a preceding load is forwarded, not stalled.
    fwd_match u_match_s (
        .i_en          (reads_rd(IFID_OPCODE)),
        .i_load_stalls (1'b0),
        .i_addr        (IFID_RD_ADDR),
        .i_idex_valid  (r_idex_valid),
        .i_idex_rd     (r_idex_rd),
        .i_idex_cls    (r_idex_cls),
        .i_exmem_valid (r_exmem_valid),
        .i_exmem_rd    (r_exmem_rd),
        .i_exmem_cls   (r_exmem_cls),
        .o_code        (w_code_s),
        .o_stall       (w_stall_s)
    );

    assign w_stall  = !FLUSH && (w_stall_a || w_stall_b || w_stall_s);
    assign w_bubble = FLUSH || w_stall;
    assign STALL    = w_stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_RUN;
            r_idex_valid  <= 1'b0;
            r_idex_rd     <= 3'd0;
            r_idex_cls    <= CLS_NONE;
            r_exmem_valid <= 1'b0;
            r_exmem_rd    <= 3'd0;
            r_exmem_cls   <= CLS_NONE;
            RAM_FORWARD   <= c_fwd_rf;
            ALU_FWD_A     <= c_fwd_rf;
            ALU_FWD_B     <= c_fwd_rf;
        end else begin
            r_exmem_valid <= r_idex_valid;
            r_exmem_rd    <= r_idex_rd;
            r_exmem_cls   <= r_idex_cls;
            if (w_bubble) begin
                r_idex_valid <= 1'b0;
                r_idex_rd    <= 3'd0;
                r_idex_cls   <= CLS_NONE;
                RAM_FORWARD  <= c_fwd_rf;
                ALU_FWD_A    <= c_fwd_rf;
                ALU_FWD_B    <= c_fwd_rf;
            end else begin
                r_idex_valid <= (w_cls != CLS_NONE);
                r_idex_rd    <= IFID_RD_ADDR;
                r_idex_cls   <= w_cls;
                RAM_FORWARD  <= w_code_s;
                ALU_FWD_A    <= w_code_a;
                ALU_FWD_B    <= w_code_b;
            end
            case (r_state)
                ST_RUN:  if (w_stall)  r_state <= ST_HOLD;
                ST_HOLD: if (!w_stall) r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_forward_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_control
// Description : Randomized scoreboard bench for forward_control; honours the
//               FWD_MEMWB_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_forward_control;
    import forward_control_pkg::*;

`ifdef FWD_MEMWB_EN
    localparam bit MEMWB_EN = 1'b1;
`else
    localparam bit MEMWB_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [4:0] IFID_OPCODE = c_op_nop;
    logic [2:0] IFID_RD_ADDR = 3'd0;
    logic [3:0] IFID_R1_ADDR = 4'd0;
    logic [3:0] IFID_R2_ADDR = 4'd0;
    logic       FLUSH = 1'b0;
    logic       STALL;
    logic [2:0] RAM_FORWARD;
    logic [2:0] ALU_FWD_A;
    logic [2:0] ALU_FWD_B;

    forward_control dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .IFID_OPCODE  (IFID_OPCODE),
        .IFID_RD_ADDR (IFID_RD_ADDR),
        .IFID_R1_ADDR (IFID_R1_ADDR),
        .IFID_R2_ADDR (IFID_R2_ADDR),
        .FLUSH        (FLUSH),
        .STALL        (STALL),
        .RAM_FORWARD  (RAM_FORWARD),
        .ALU_FWD_A    (ALU_FWD_A),
        .ALU_FWD_B    (ALU_FWD_B)
    );

    always #5 CLK = ~CLK;

    // kind: 0 none/bubble, 1 ALU, 2 load, 3 li
    typedef struct { bit w; bit [2:0] rd; int kind; } ent_t;
    typedef struct { bit [2:0] ram; bit [2:0] a; bit [2:0] b; } exp_t;

    ent_t hist[$];   // instructions that entered IDEX, newest last
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_on = 1'b0;

    bit [4:0] specials [10] = '{c_op_bne, c_op_be, c_op_j, c_op_bner, c_op_ber,
                                c_op_jr, c_op_load, c_op_li, c_op_store, c_op_nop};

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    function automatic int kind_of(input bit [4:0] op);
        case (op)
            c_op_load: return 2;
            c_op_li:   return 3;
            c_op_bne, c_op_be, c_op_j, c_op_bner, c_op_ber,
            c_op_jr, c_op_store, c_op_nop: return 0;
            default:   return 1;
        endcase
    endfunction

    // Forward-code table: age 0 = producer one ahead, age 1 = two ahead.
    function automatic bit [2:0] code_tbl(input int kind, input int age);
        if (age == 0) return (kind == 1) ? 3'b001 : (kind == 2) ? 3'b010 : 3'b011;
        return (kind == 1) ? 3'b101 : (kind == 2) ? 3'b110 : 3'b111;
    endfunction

    function automatic void resolve(input bit en, input bit [2:0] addr, input bit load_stalls,
                                    output bit [2:0] code, output bit st);
        ent_t e;
        code = 3'b000;
        st   = 1'b0;
        if (!en) return;
        for (int age = 0; age < 2; age++) begin
            e = hist[hist.size() - 1 - age];
            if (e.w && e.rd == addr) begin
                if (age == 0 && e.kind == 2 && load_stalls) st = 1'b1;
                if (age == 1 && !MEMWB_EN) st = 1'b1;
                code = code_tbl(e.kind, age);
                return;
            end
        end
    endfunction

    task automatic reset_model();
        ent_t b;
        b = '{w: 1'b0, rd: 3'd0, kind: 0};
        hist.delete();
        hist.push_back(b);
        hist.push_back(b);
        sbq.delete();
    endtask

    // One clock: drive at negedge, check STALL, predict registered codes.
    task automatic step(input bit [4:0] op, input bit [2:0] rd, input bit [3:0] r1,
                        input bit [3:0] r2, input bit fl, output bit stalled);
        int k;
        bit ra, rb, rs, sa, sb, ss, m_stall;
        bit [2:0] ca, cb, cs;
        exp_t ex;
        ent_t ne;
        IFID_OPCODE = op; IFID_RD_ADDR = rd; IFID_R1_ADDR = r1; IFID_R2_ADDR = r2; FLUSH = fl;
        #1;
        k  = kind_of(op);
        ra = (k == 1) || op == c_op_bner || op == c_op_ber || op == c_op_jr;
        rb = (k == 1) || op == c_op_bner || op == c_op_ber;
        rs = (op == c_op_store);
        resolve(ra, r1[2:0], 1'b1, ca, sa);
        resolve(rb, r2[2:0], 1'b1, cb, sb);
        resolve(rs, rd, 1'b0, cs, ss);
        m_stall = !fl && (sa || sb || ss);
        chk("stall", {2'b00, STALL}, {2'b00, m_stall});
        if (fl || m_stall) begin
            ex = '{ram: 3'b000, a: 3'b000, b: 3'b000};
            ne = '{w: 1'b0, rd: 3'd0, kind: 0};
        end else begin
            ex = '{ram: cs, a: ca, b: cb};
            ne = '{w: (k != 0), rd: rd, kind: k};
        end
        @(posedge CLK);
        sbq.push_back(ex);
        hist.push_back(ne);
        void'(hist.pop_front());
        @(negedge CLK);
        stalled = m_stall;
    endtask

    task automatic issue(input bit [4:0] op, input bit [2:0] rd, input bit [3:0] r1,
                         input bit [3:0] r2, input bit fl);
        bit s;
        int n;
        n = 0;
        do begin
            step(op, rd, r1, r2, fl, s);
            n++;
        end while (s && n < 4);
        chk("stall_bound", {2'b00, s}, 3'b000);
    endtask

    // Monitor: one registered result per clock while the driver is stepping.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (sb_on) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("ram_forward", RAM_FORWARD, e.ram);
                    chk("alu_fwd_a", ALU_FWD_A, e.a);
                    chk("alu_fwd_b", ALU_FWD_B, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        bit [4:0] op;
        reset_model();
        #3;
        chk("reset_stall", {2'b00, STALL}, 3'b000);
        chk("reset_ram", RAM_FORWARD, 3'b000);
        chk("reset_a", ALU_FWD_A, 3'b000);
        chk("reset_b", ALU_FWD_B, 3'b000);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        sb_on = 1'b1;

        // ALU producer straight into ALU consumer
        issue(5'h01, 3'd3, 4'd0, 4'd1, 1'b0);
        issue(5'h02, 3'd5, 4'd3, 4'd1, 1'b0);
        // li, nop, store of the li result
        issue(c_op_li, 3'd2, 4'd0, 4'd0, 1'b0);
        issue(c_op_nop, 3'd0, 4'd0, 4'd0, 1'b0);
        issue(c_op_store, 3'd2, 4'd0, 4'd0, 1'b0);
        // load-use on R2
        issue(c_op_load, 3'd4, 4'd0, 4'd0, 1'b0);
        issue(5'h03, 3'd1, 4'd0, 4'd4, 1'b0);
        // load then store of the loaded register
        issue(c_op_load, 3'd4, 4'd0, 4'd0, 1'b0);
        issue(c_op_store, 3'd4, 4'd0, 4'd0, 1'b0);
        // flush overriding a load-use stall
        issue(c_op_load, 3'd4, 4'd0, 4'd0, 1'b0);
        issue(5'h04, 3'd1, 4'd4, 4'd4, 1'b1);
        issue(c_op_nop, 3'd0, 4'd0, 4'd0, 1'b0);

        // reset while holding on a load-use
        issue(c_op_load, 3'd6, 4'd0, 4'd0, 1'b0);
        step(5'h05, 3'd1, 4'd6, 4'd0, 1'b0, s);
        sb_on = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("midreset_stall", {2'b00, STALL}, 3'b000);
        chk("midreset_ram", RAM_FORWARD, 3'b000);
        chk("midreset_a", ALU_FWD_A, 3'b000);
        chk("midreset_b", ALU_FWD_B, 3'b000);
        @(negedge CLK);
        reset_model();
        RST_N = 1'b1;
        sb_on = 1'b1;
        issue(5'h06, 3'd5, 4'd0, 4'd0, 1'b0);
        issue(5'h07, 3'd0, 4'd1, 4'd5, 1'b0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) < 8) op = 5'($urandom_range(0, 15));
            else op = specials[$urandom_range(0, 9)];
            issue(op, 3'($urandom_range(0, 3)),
                  {1'($urandom_range(0, 1)), 3'($urandom_range(0, 3))},
                  {1'($urandom_range(0, 1)), 3'($urandom_range(0, 3))},
                  ($urandom_range(0, 9) == 0));
        end

        sb_on = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
